recon_stream_ctrl: RTL

RECON_STREAM_CTRL -- requirements
Module: recon_stream_ctrl

---
 rtl/recon_stream_ctrl.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/recon_stream_ctrl.sv
// rtl/recon_stream_ctrl.sv - recon frame parser: bitstream table, DMA descriptors, payload realignment
// Header beat is decoded in IDLE; store payload is shifted down so the first payload byte lands at byte 0.
module recon_stream_ctrl #(
   parameter int          DATA_WIDTH = 512,
   parameter int          KEEP_WIDTH = DATA_WIDTH/8,
   parameter int          ADDR_WIDTH = 34,
   parameter int          LEN_WIDTH  = 20,
   parameter int          TAG_WIDTH  = 8,
   parameter int          HDR_OFFSET = 46,
   parameter logic [15:0] MAGIC      = 16'hF0E1,
   parameter int          SLOTS      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   input  logic                  m_axis_tready,
   output logic [ADDR_WIDTH-1:0] m_axis_write_desc_addr,
   output logic [LEN_WIDTH-1:0]  m_axis_write_desc_len,
   output logic [TAG_WIDTH-1:0]  m_axis_write_desc_tag,
   output logic                  m_axis_write_desc_valid,
   input  logic                  m_axis_write_desc_ready,
   output logic [ADDR_WIDTH-1:0] m_axis_read_desc_addr,
   output logic [LEN_WIDTH-1:0]  m_axis_read_desc_len,
   output logic [TAG_WIDTH-1:0]  m_axis_read_desc_tag,
   output logic                  m_axis_read_desc_valid,
   input  logic                  m_axis_read_desc_ready,
   output logic                  status_busy,
   output logic                  status_err,
   output logic [31:0]           status_frames
);
   localparam int S  = HDR_OFFSET + 10;
   localparam int R  = KEEP_WIDTH - S;
   localparam int SB = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [LEN_WIDTH-1:0] KW_L = LEN_WIDTH'(KEEP_WIDTH);
   localparam logic [LEN_WIDTH-1:0] R_L  = LEN_WIDTH'(R);

   typedef enum logic [2:0] {IDLE, WR_DESC, STREAM, RD_DESC, DROP} state_t;
   state_t state, state_nxt;

   logic [LEN_WIDTH-1:0]  rem;
   logic [R*8-1:0]        residual;
   logic                  flush, hdr_last;
   logic                  wr_valid, rd_valid;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [LEN_WIDTH-1:0]  d_len;
   logic [TAG_WIDTH-1:0]  d_tag;
   logic [ADDR_WIDTH-1:0] tbl_addr [SLOTS];
   logic [LEN_WIDTH-1:0]  tbl_len  [SLOTS];
   logic [SLOTS-1:0]      tbl_valid;

   function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [LEN_WIDTH-1:0] n);
      logic [KEEP_WIDTH-1:0] m;
      for (int i = 0; i < KEEP_WIDTH; i++) m[i] = (LEN_WIDTH'(i) < n);
      return m;
   endfunction

   // Header field decode straight off the input beat
   logic [15:0]           h_magic;
   logic [1:0]            h_func;
   logic                  h_size_valid;
   logic [ADDR_WIDTH-1:0] h_addr;
   logic [7:0]            h_id;
   logic [31:0]           h_size;
   logic [SB-1:0]         h_slot;
   assign h_magic      = s_axis_tdata[(HDR_OFFSET-4)*8 +: 16];
   assign h_func       = s_axis_tdata[HDR_OFFSET*8 +: 2];
   assign h_size_valid = s_axis_tdata[HDR_OFFSET*8 + 2];
   assign h_addr       = s_axis_tdata[HDR_OFFSET*8 + 3 +: ADDR_WIDTH];
   assign h_id         = s_axis_tdata[HDR_OFFSET*8 + 37 +: 8];
   assign h_size       = s_axis_tdata[HDR_OFFSET*8 + 45 +: 32];
   assign h_slot       = h_id[SB-1:0];

   logic hdr_good, size_ok, go_store, go_load, hdr_err;
   assign hdr_good = (h_magic == MAGIC) && h_size_valid;
   assign size_ok  = (h_size != 32'd0) && ((h_size >> LEN_WIDTH) == 32'd0);
   assign go_store = hdr_good && (h_func == 2'd0) && size_ok;
   assign go_load  = hdr_good && (((h_func == 2'd1) && size_ok) ||
                                  ((h_func == 2'd2) && tbl_valid[h_slot]));
   assign hdr_err  = hdr_good && (((h_func[1] == 1'b0) && !size_ok) ||
                                  ((h_func == 2'd2) && !tbl_valid[h_slot]));

   logic out_ready, in_fire, wr_hs, rd_hs;
   assign out_ready = m_axis_tready || !m_axis_tvalid;
   assign in_fire   = s_axis_tvalid && s_axis_tready;
   assign wr_hs     = wr_valid && m_axis_write_desc_ready;
   assign rd_hs     = rd_valid && m_axis_read_desc_ready;

   logic unused_bits;
   assign unused_bits = ^s_axis_tkeep;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (s_axis_tvalid) begin
            if (go_store)           state_nxt = WR_DESC;
            else if (go_load)       state_nxt = RD_DESC;
            else if (!s_axis_tlast) state_nxt = DROP;
         end
         WR_DESC: if (wr_hs) state_nxt = STREAM;
         STREAM: begin
            if (flush && out_ready)
               state_nxt = IDLE;
            else if (in_fire && rem <= KW_L)
               state_nxt = s_axis_tlast ? IDLE : DROP;
         end
         RD_DESC: if (rd_hs) state_nxt = hdr_last ? IDLE : DROP;
         DROP:    if (s_axis_tvalid && s_axis_tlast) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_axis_tready = 1'b0;
      case (state)
         IDLE, DROP: s_axis_tready = 1'b1;
         STREAM:     s_axis_tready = out_ready && !flush;
         default:    s_axis_tready = 1'b0;
      endcase
      status_busy = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_valid      <= 1'b0;
         rd_valid      <= 1'b0;
         d_addr        <= '0;
         d_len         <= '0;
         d_tag         <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         status_err    <= 1'b0;
         status_frames <= '0;
         rem           <= '0;
         residual      <= '0;
         flush         <= 1'b0;
         hdr_last      <= 1'b0;
         tbl_valid     <= '0;
      end else begin
         status_err <= 1'b0;
         if (m_axis_tready) m_axis_tvalid <= 1'b0;
         if (wr_hs) begin
            wr_valid      <= 1'b0;
            status_frames <= status_frames + 32'd1;
            flush         <= hdr_last;    // header-only store: residual is all the payload there is
         end
         if (rd_hs) begin
            rd_valid      <= 1'b0;
            status_frames <= status_frames + 32'd1;
         end
         case (state)
            IDLE: if (s_axis_tvalid) begin
               hdr_last <= s_axis_tlast;
               d_tag    <= h_id[TAG_WIDTH-1:0];
               if (hdr_err) status_err <= 1'b1;
               if (go_store) begin
                  wr_valid          <= 1'b1;
                  d_addr            <= h_addr;
                  d_len             <= h_size[LEN_WIDTH-1:0];
                  rem               <= h_size[LEN_WIDTH-1:0];
                  residual          <= s_axis_tdata[DATA_WIDTH-1 -: R*8];
                  tbl_addr[h_slot]  <= h_addr;
                  tbl_len[h_slot]   <= h_size[LEN_WIDTH-1:0];
                  tbl_valid[h_slot] <= 1'b1;
               end else if (go_load) begin
                  rd_valid <= 1'b1;
                  d_addr   <= (h_func == 2'd1) ? h_addr : tbl_addr[h_slot];
                  d_len    <= (h_func == 2'd1) ? h_size[LEN_WIDTH-1:0] : tbl_len[h_slot];
               end
            end
            STREAM: begin
               if (in_fire) begin
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= {s_axis_tdata[S*8-1:0], residual};
                  residual      <= s_axis_tdata[DATA_WIDTH-1 -: R*8];
                  if (rem <= KW_L) begin
                     m_axis_tkeep <= keep_mask(rem);
                     m_axis_tlast <= 1'b1;
                  end else begin
                     m_axis_tkeep <= '1;
                     m_axis_tlast <= 1'b0;
                     rem          <= rem - KW_L;
                     flush        <= s_axis_tlast;
                  end
               end else if (flush && out_ready) begin
                  // Last input beat seen; residual carries the tail, short if the frame was truncated
                  m_axis_tvalid <= 1'b1;
                  m_axis_tdata  <= {{(S*8){1'b0}}, residual};
                  m_axis_tkeep  <= keep_mask((rem > R_L) ? R_L : rem);
                  m_axis_tlast  <= 1'b1;
                  flush         <= 1'b0;
                  if (rem > R_L) status_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign m_axis_write_desc_addr  = d_addr;
   assign m_axis_write_desc_len   = d_len;
   assign m_axis_write_desc_tag   = d_tag;
   assign m_axis_write_desc_valid = wr_valid;
   assign m_axis_read_desc_addr   = d_addr;
   assign m_axis_read_desc_len    = d_len;
   assign m_axis_read_desc_tag    = d_tag;
   assign m_axis_read_desc_valid  = rd_valid;
endmodule
